// File: rtl/lfsr_bank_ctrl.sv
// Seed-load and stream-window sequencer for one LFSR bank.
// Every output is a register; ABORT cancels any load or run in progress.
module lfsr_bank_ctrl #(
    parameter int N_L     = 32,
    parameter int N_L_REG = 3,
    parameter int CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CFG_START,
    input  logic               SEED_VALID,
    output logic               SEED_READY,
    input  logic [N_L-1:0]     SEED_DATA,
    output logic               SEED_DONE,
    input  logic               RUN_START,
    input  logic [CNT_W-1:0]   RUN_LEN,
    input  logic               RUN_OPTION,
    input  logic               ABORT,
    output logic               BUSY,
    output logic               SAMPLE_VALID,
    output logic               RUN_DONE,
    output logic               lfsr_load,
    output logic [N_L_REG-1:0] lfsr_sel,
    output logic               lfsr_en,
    output logic               lfsr_option_sel,
    output logic [N_L-1:0]     LFSR_REG_INIT
);

    localparam int IDX_W = (N_L_REG > 1) ? $clog2(N_L_REG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   index_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [N_L_REG-1:0] sel_decode;
    logic               last_seed;

    // One-hot decode of the register currently being seeded.
    generate
        for (genvar gi = 0; gi < N_L_REG; gi++) begin : g_sel
            assign sel_decode[gi] = (index_reg == IDX_W'(gi));
        end
    endgenerate

    assign last_seed = (index_reg == IDX_W'(N_L_REG - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            index_reg       <= '0;
            cnt_reg         <= '0;
            SEED_READY      <= 1'b0;
            SEED_DONE       <= 1'b0;
            BUSY            <= 1'b0;
            SAMPLE_VALID    <= 1'b0;
            RUN_DONE        <= 1'b0;
            lfsr_load       <= 1'b0;
            lfsr_sel        <= '0;
            lfsr_en         <= 1'b0;
            lfsr_option_sel <= 1'b0;
            LFSR_REG_INIT   <= '0;
        end else begin
            SEED_DONE <= 1'b0;
            RUN_DONE  <= 1'b0;
            lfsr_load <= 1'b0;
            lfsr_sel  <= '0;

            if (ABORT) begin
                // Drops any pending seed and the window; option and last seed word stay.
                state_reg    <= ST_IDLE;
                index_reg    <= '0;
                cnt_reg      <= '0;
                SEED_READY   <= 1'b0;
                BUSY         <= 1'b0;
                SAMPLE_VALID <= 1'b0;
                lfsr_en      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (CFG_START) begin
                            state_reg  <= ST_LOAD;
                            index_reg  <= '0;
                            SEED_READY <= 1'b1;
                            BUSY       <= 1'b1;
                        end else if (RUN_START) begin
                            if (RUN_LEN != '0) begin
                                state_reg       <= ST_RUN;
                                cnt_reg         <= RUN_LEN;
                                lfsr_option_sel <= RUN_OPTION;
                                lfsr_en         <= 1'b1;
                                SAMPLE_VALID    <= 1'b1;
                                BUSY            <= 1'b1;
                            end else begin
                                RUN_DONE <= 1'b1;
                            end
                        end
                    end

                    ST_LOAD: begin
                        if (SEED_VALID && SEED_READY) begin
                            lfsr_load     <= 1'b1;
                            lfsr_sel      <= sel_decode;
                            LFSR_REG_INIT <= SEED_DATA;
                            if (last_seed) begin
                                state_reg  <= ST_IDLE;
                                index_reg  <= '0;
                                SEED_READY <= 1'b0;
                                BUSY       <= 1'b0;
                                SEED_DONE  <= 1'b1;
                            end else begin
                                index_reg <= index_reg + 1'b1;
                            end
                        end
                    end

                    ST_RUN: begin
                        // cnt counts the window cycles still to be shown, including this one.
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg    <= ST_IDLE;
                            cnt_reg      <= '0;
                            lfsr_en      <= 1'b0;
                            SAMPLE_VALID <= 1'b0;
                            BUSY         <= 1'b0;
                            RUN_DONE     <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end

                    default: begin
                        state_reg    <= ST_IDLE;
                        index_reg    <= '0;
                        cnt_reg      <= '0;
                        SEED_READY   <= 1'b0;
                        BUSY         <= 1'b0;
                        SAMPLE_VALID <= 1'b0;
                        lfsr_en      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_bank_ctrl.sv
// Randomised bench for lfsr_bank_ctrl: scenario tasks compare the DUT against
// expectations derived from a seed list, window lengths and a model of the bank.
module tb_lfsr_bank_ctrl;

    localparam int N_L     = 32;
    localparam int N_L_REG = 3;
    localparam int CNT_W   = 8;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               CFG_START;
    logic               SEED_VALID;
    logic               SEED_READY;
    logic [N_L-1:0]     SEED_DATA;
    logic               SEED_DONE;
    logic               RUN_START;
    logic [CNT_W-1:0]   RUN_LEN;
    logic               RUN_OPTION;
    logic               ABORT;
    logic               BUSY;
    logic               SAMPLE_VALID;
    logic               RUN_DONE;
    logic               lfsr_load;
    logic [N_L_REG-1:0] lfsr_sel;
    logic               lfsr_en;
    logic               lfsr_option_sel;
    logic [N_L-1:0]     LFSR_REG_INIT;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic exp_option = 1'b0;
    logic [N_L-1:0] bank_model [N_L_REG];

    lfsr_bank_ctrl #(.N_L(N_L), .N_L_REG(N_L_REG), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .CFG_START(CFG_START), .SEED_VALID(SEED_VALID),
        .SEED_READY(SEED_READY), .SEED_DATA(SEED_DATA), .SEED_DONE(SEED_DONE),
        .RUN_START(RUN_START), .RUN_LEN(RUN_LEN), .RUN_OPTION(RUN_OPTION),
        .ABORT(ABORT), .BUSY(BUSY), .SAMPLE_VALID(SAMPLE_VALID), .RUN_DONE(RUN_DONE),
        .lfsr_load(lfsr_load), .lfsr_sel(lfsr_sel), .lfsr_en(lfsr_en),
        .lfsr_option_sel(lfsr_option_sel), .LFSR_REG_INIT(LFSR_REG_INIT)
    );

    always #5 CLK = ~CLK;

    // Behaviour of the bank itself: a register captures INIT when selected by a load.
    always @(posedge CLK) begin
        if (lfsr_load) begin
            for (int i = 0; i < N_L_REG; i++)
                if (lfsr_sel[i]) bank_model[i] <= LFSR_REG_INIT;
        end
    end

    // Structural invariants, checked every cycle away from the active edge.
    always @(negedge CLK) begin
        if (mon_en) begin
            checks++;
            if ((lfsr_load && lfsr_en) || !$onehot0(lfsr_sel)) begin
                errors++;
                $display("FAIL invariant t=%0t: load=%b en=%b sel=%b required load&en=0, sel one-hot or zero",
                         $time, lfsr_load, lfsr_en, lfsr_sel);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        logic [N_L_REG+8:0] got;
        got = {SEED_READY, SEED_DONE, BUSY, SAMPLE_VALID, RUN_DONE, lfsr_load, lfsr_sel, lfsr_en, lfsr_option_sel};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero", got);
        end
        checks++;
        if (LFSR_REG_INIT !== '0) begin
            errors++;
            $display("FAIL reset_init: got %h required 0", LFSR_REG_INIT);
        end
        $display("reset check: outputs=%b init=%h", got, LFSR_REG_INIT);
    endtask

    // Assumes the controller is already in LOAD; feeds N_L_REG seeds with `gap` idle cycles before each.
    task automatic load_seeds(input int gap);
        logic [N_L-1:0]     seeds [N_L_REG];
        logic [N_L_REG+4:0] got, exp;
        logic               last;
        for (int i = 0; i < N_L_REG; i++) begin
            seeds[i] = $urandom;
            for (int g = 0; g < gap; g++) begin
                SEED_VALID = 1'b0;
                SEED_DATA  = $urandom;
                step;
                got = {lfsr_load, lfsr_sel, SEED_READY, SEED_DONE, BUSY, lfsr_en};
                exp = {1'b0, {N_L_REG{1'b0}}, 1'b1, 1'b0, 1'b1, 1'b0};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL load_gap seed%0d: got %b required %b", i, got, exp);
                end
            end
            SEED_VALID = 1'b1;
            SEED_DATA  = seeds[i];
            step;
            SEED_VALID = 1'b0;
            last = (i == N_L_REG - 1);
            got = {lfsr_load, lfsr_sel, SEED_READY, SEED_DONE, BUSY, lfsr_en};
            exp = {1'b1, N_L_REG'(1 << i), !last, last, !last, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_pulse seed%0d: got %b required %b", i, got, exp);
            end
            checks++;
            if (LFSR_REG_INIT !== seeds[i]) begin
                errors++;
                $display("FAIL load_init seed%0d: got %h required %h", i, LFSR_REG_INIT, seeds[i]);
            end
            $display("load seed%0d: data=%h sel=%b done=%b", i, seeds[i], lfsr_sel, SEED_DONE);
        end
        step;
        checks++;
        if ({lfsr_load, SEED_DONE, lfsr_sel, SEED_READY} !== '0 || LFSR_REG_INIT !== seeds[N_L_REG-1]) begin
            errors++;
            $display("FAIL load_after: load=%b done=%b sel=%b ready=%b init=%h required zeros, init %h",
                     lfsr_load, SEED_DONE, lfsr_sel, SEED_READY, LFSR_REG_INIT, seeds[N_L_REG-1]);
        end
        for (int i = 0; i < N_L_REG; i++) begin
            checks++;
            if (bank_model[i] !== seeds[i]) begin
                errors++;
                $display("FAIL bank_contents reg%0d: got %h required %h", i, bank_model[i], seeds[i]);
            end
        end
    endtask

    task automatic test_seed_load(input int gap);
        CFG_START = 1'b1;
        step;
        CFG_START = 1'b0;
        checks++;
        if ({SEED_READY, BUSY, lfsr_load} !== 3'b110) begin
            errors++;
            $display("FAIL load_entry: ready/busy/load got %b required 110", {SEED_READY, BUSY, lfsr_load});
        end
        load_seeds(gap);
    endtask

    task automatic test_run(input int len, input logic opt, input logic collide);
        logic [6:0] got, exp;
        int         en_cycles = 0;
        logic       want_opt;
        RUN_LEN    = CNT_W'(len);
        RUN_OPTION = opt;
        RUN_START  = 1'b1;
        step;
        RUN_START  = 1'b0;
        RUN_LEN    = CNT_W'($urandom);
        RUN_OPTION = ~opt;
        if (len != 0) exp_option = opt;
        want_opt = exp_option;
        for (int c = 0; c <= len + 1; c++) begin
            got = {BUSY, SAMPLE_VALID, lfsr_en, RUN_DONE, lfsr_option_sel, lfsr_load, SEED_READY};
            exp = {c < len, c < len, c < len, c == len, want_opt, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run len=%0d cycle%0d: got %b required %b", len, c + 1, got, exp);
            end
            if (lfsr_en) en_cycles++;
            if (collide && c == 1 && len > 2) begin
                RUN_START = 1'b1;
                CFG_START = 1'b1;
                RUN_LEN   = CNT_W'(len + 7);
            end
            step;
            RUN_START = 1'b0;
            CFG_START = 1'b0;
        end
        checks++;
        if (en_cycles != len) begin
            errors++;
            $display("FAIL run_length: got %0d enabled cycles required %0d", en_cycles, len);
        end
        $display("run len=%0d opt=%b collide=%b: en_cycles=%0d", len, opt, collide, en_cycles);
    endtask

    task automatic test_cfg_run_collision;
        logic [4:0] got, exp;
        CFG_START  = 1'b1;
        RUN_START  = 1'b1;
        RUN_LEN    = 8'd5;
        RUN_OPTION = ~exp_option;
        step;
        CFG_START  = 1'b0;
        RUN_START  = 1'b0;
        got = {SEED_READY, BUSY, lfsr_en, SAMPLE_VALID, lfsr_option_sel};
        exp = {1'b1, 1'b1, 1'b0, 1'b0, exp_option};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cfg_run_collision: got %b required %b", got, exp);
        end
        $display("collision cfg+run: ready/busy/en/valid/opt=%b", got);
        load_seeds(0);
    endtask

    task automatic test_abort_load;
        logic [N_L-1:0]     s0, s1, old1;
        logic [N_L_REG+5:0] got;
        old1 = bank_model[1];
        s0 = $urandom;
        s1 = ~old1;
        CFG_START = 1'b1;
        step;
        CFG_START  = 1'b0;
        SEED_VALID = 1'b1;
        SEED_DATA  = s0;
        step;
        SEED_DATA  = s1;
        ABORT      = 1'b1;
        step;
        ABORT      = 1'b0;
        SEED_VALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = {lfsr_load, lfsr_sel, SEED_READY, SEED_DONE, BUSY, lfsr_en, SAMPLE_VALID};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL abort_load cycle%0d: got %b required all zero", c, got);
            end
            step;
        end
        checks++;
        if (bank_model[0] !== s0 || bank_model[1] !== old1) begin
            errors++;
            $display("FAIL abort_bank: reg0 %h reg1 %h required %h %h", bank_model[0], bank_model[1], s0, old1);
        end
        $display("abort on 2nd seed: reg0=%h reg1=%h", bank_model[0], bank_model[1]);
    endtask

    task automatic test_abort_run;
        int en_cycles = 0;
        RUN_LEN    = 8'd10;
        RUN_OPTION = $urandom_range(0, 1);
        exp_option = RUN_OPTION;
        RUN_START  = 1'b1;
        step;
        RUN_START = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (lfsr_en) en_cycles++;
            if (c == 3) ABORT = 1'b1;
            step;
        end
        ABORT = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({lfsr_en, SAMPLE_VALID, BUSY, RUN_DONE} !== 4'b0 || lfsr_option_sel !== exp_option) begin
                errors++;
                $display("FAIL abort_run +%0d: en/valid/busy/done got %b opt %b required 0000 opt %b",
                         c, {lfsr_en, SAMPLE_VALID, BUSY, RUN_DONE}, lfsr_option_sel, exp_option);
            end
            step;
        end
        checks++;
        if (en_cycles != 3) begin
            errors++;
            $display("FAIL abort_run_length: got %0d enabled cycles required 3", en_cycles);
        end
        $display("abort run at cycle 3: en_cycles=%0d", en_cycles);
    endtask

    task automatic test_reset_mid_run;
        RUN_LEN    = 8'd20;
        RUN_OPTION = 1'b1;
        RUN_START  = 1'b1;
        step;
        RUN_START = 1'b0;
        repeat (4) step;
        RESET = 1'b1;
        step;
        test_reset;
        RESET = 1'b0;
        exp_option = 1'b0;
        step;
    endtask

    initial begin
        RESET      = 1'b1;
        CFG_START  = 1'b0;
        SEED_VALID = 1'b0;
        SEED_DATA  = '0;
        RUN_START  = 1'b0;
        RUN_LEN    = '0;
        RUN_OPTION = 1'b0;
        ABORT      = 1'b0;
        for (int i = 0; i < N_L_REG; i++) bank_model[i] = '0;
        repeat (3) step;
        test_reset;
        RESET  = 1'b0;
        mon_en = 1'b1;
        step;

        test_seed_load(0);
        test_seed_load(2);
        test_run(5, 1'b1, 1'b0);
        repeat (4) test_run($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1);
        test_run(0, ~exp_option, 1'b0);
        test_cfg_run_collision;
        test_abort_load;
        test_seed_load(1);
        test_abort_run;
        test_reset_mid_run;
        test_seed_load(0);
        test_run(5, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
